// File: rtl/gol_pkg.sv
// rtl/gol_pkg.sv - shared state encoding and B3/S23 constants for the Game of Life generation engine
package gol_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_TOP,
    LOAD_CUR,
    FETCH,
    WRITE,
    DONE
  } gol_state_t;

  localparam int GOL_BIRTH   = 3;
  localparam int GOL_SURVIVE = 2;

endpackage

// File: rtl/gol_row_rule.sv
// rtl/gol_row_rule.sv - combinational B3/S23 next-row logic from three stacked rows
// GOL_TORUS_EN wraps column WIDTH-1 onto column 0; otherwise off-board columns read as dead.
module gol_row_rule
  import gol_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] nxt,
  output logic [WIDTH-1:0] next_row
);

  // Each row padded by one column on both sides; ext index j+1 holds column j.
  logic [WIDTH+1:0] p_ext;
  logic [WIDTH+1:0] c_ext;
  logic [WIDTH+1:0] n_ext;

`ifdef GOL_TORUS_EN
  assign p_ext = {prev[0], prev, prev[WIDTH-1]};
  assign c_ext = {cur[0], cur, cur[WIDTH-1]};
  assign n_ext = {nxt[0], nxt, nxt[WIDTH-1]};
`else
  assign p_ext = {1'b0, prev, 1'b0};
  assign c_ext = {1'b0, cur, 1'b0};
  assign n_ext = {1'b0, nxt, 1'b0};
`endif

  always_comb begin
    logic [3:0] cnt;
    cnt      = '0;
    next_row = '0;
    for (int j = 0; j < WIDTH; j++) begin
      cnt = 4'(p_ext[j]) + 4'(p_ext[j+1]) + 4'(p_ext[j+2])
          + 4'(c_ext[j])                  + 4'(c_ext[j+2])
          + 4'(n_ext[j]) + 4'(n_ext[j+1]) + 4'(n_ext[j+2]);
      next_row[j] = (cnt == 4'(GOL_BIRTH)) ||
                    ((cnt == 4'(GOL_SURVIVE)) && c_ext[j+1]);
    end
  end

endmodule

// File: rtl/gol_next_gen.sv
// rtl/gol_next_gen.sv - in-place next-generation engine driving the row register file
// GOL_TORUS_EN selects a toroidal board; undefined means dead cells beyond every edge.
module gol_next_gen
  import gol_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3,
  parameter int GENBITS = 16
) (
  input  logic               ph2,
  input  logic               reset,
  input  logic               start,
  output logic [REGBITS-1:0] ra,
  input  logic [WIDTH-1:0]   rd,
  output logic [WIDTH-1:0]   wd,
  output logic               regwrite,
  output logic               busy,
  output logic               done,
  output logic [GENBITS-1:0] gen_count
);

  localparam logic [REGBITS-1:0] LAST = '1;

  gol_state_t         state, state_next;
  logic [REGBITS-1:0] i;
  logic [WIDTH-1:0]   prev, cur, nxt;
  logic [WIDTH-1:0]   rule_row;
`ifdef GOL_TORUS_EN
  // Original row 0, needed as the lower neighbour of row N-1 after row 0 is rewritten.
  logic [WIDTH-1:0]   row0;
`endif

  gol_row_rule #(.WIDTH(WIDTH)) u_rule (
    .prev     (prev),
    .cur      (cur),
    .nxt      (nxt),
    .next_row (rule_row)
  );

  always_ff @(posedge ph2) begin
    if (reset) begin
      state     <= IDLE;
      i         <= '0;
      prev      <= '0;
      cur       <= '0;
      nxt       <= '0;
      gen_count <= '0;
`ifdef GOL_TORUS_EN
      row0      <= '0;
`endif
    end else begin
      state <= state_next;
      case (state)
        LOAD_TOP: begin
`ifdef GOL_TORUS_EN
          prev <= rd;
`else
          prev <= '0;
`endif
        end
        LOAD_CUR: begin
          cur <= rd;
          i   <= '0;
`ifdef GOL_TORUS_EN
          row0 <= rd;
`endif
        end
        FETCH: begin
          if (i == LAST) begin
`ifdef GOL_TORUS_EN
            nxt <= row0;
`else
            nxt <= '0;
`endif
          end else begin
            nxt <= rd;
          end
        end
        WRITE: begin
          prev <= cur;
          cur  <= nxt;
          if (i != LAST) i <= i + REGBITS'(1);
        end
        DONE:    gen_count <= gen_count + GENBITS'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    ra         = '0;
    wd         = '0;
    regwrite   = 1'b0;
    case (state)
      IDLE:     if (start) state_next = LOAD_TOP;
      LOAD_TOP: begin
        ra         = LAST;
        state_next = LOAD_CUR;
      end
      LOAD_CUR: state_next = FETCH;
      FETCH: begin
        ra         = i + REGBITS'(1);
        state_next = WRITE;
      end
      WRITE: begin
        ra         = i;
        wd         = rule_row;
        // Suppress the write strobe in a reset cycle so the row is left untouched.
        regwrite   = !reset;
        state_next = (i == LAST) ? DONE : FETCH;
      end
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: doc/gol_next_gen.md
# gol_next_gen

Generation engine for the Game of Life row register file. It reads every row of the current board through the file's single address port, computes the next generation with the B3/S23 rule, and writes each new row back in place. Two row buffers preserve the original rows still needed as neighbours. It sits between the top-level step controller and the row register file, and owns that file's `ra`, `wd` and `regwrite` signals whenever it is busy.

## Interface
- `WIDTH`, 8, cells per row (row word width).
- `REGBITS`, 3, row address bits; board height N = 2**REGBITS.
- `GENBITS`, 16, width of the generation counter.

Ports:
- `ph2`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request one generation step; sampled only in IDLE.
- `ra`  out  REGBITS  row address to the register file (read and write share it).
- `rd`  in  WIDTH  combinational read data for row `ra`.
- `wd`  out  WIDTH  next-generation row data.
- `regwrite`  out  1  write strobe; high only in WRITE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a generation has been fully written.
- `gen_count`  out  GENBITS  completed generations since reset.

## Operation
- States: IDLE, LOAD_TOP, LOAD_CUR, FETCH, WRITE, DONE. The state register, row index `i` (REGBITS), and buffers `prev`, `cur`, `nxt`, `row0` (WIDTH each) are registered. `ra`, `wd` and `regwrite` are decoded combinationally from them.
- IDLE: `ra`=0, `regwrite`=0. If `start`=1, go to LOAD_TOP.
- LOAD_TOP: `ra`=N-1; `prev` <= `rd`. Go to LOAD_CUR.
- LOAD_CUR: `ra`=0; `cur` <= `rd`; `row0` <= `rd`; `i` <= 0. Go to FETCH.
- FETCH: `ra`=(i+1) mod N; `nxt` <= (i==N-1) ? `row0` : `rd`. Go to WRITE. The i==N-1 case uses `row0` because row 0 has already been overwritten.
- WRITE: `ra`=i; `regwrite`=1; `wd`=rule(`prev`,`cur`,`nxt`). Then `prev` <= `cur` and `cur` <= `nxt`. If i==N-1, go to DONE; otherwise `i` <= i+1 and go to FETCH.
- DONE: `done`=1; `gen_count` <= `gen_count`+1, wrapping modulo 2**GENBITS. Go to IDLE.
- Rule per bit j: compute a 4-bit count of the 8 neighbours. These are bits j-1, j, j+1 of `prev` and of `nxt`, plus bits j-1 and j+1 of `cur`. The cell is alive next if count==3, or if count==2 and `cur[j]`==1.
- Bit j is column j. Column neighbours of j are j-1 and j+1, with the edge treatment set under Configuration.
- `start` asserted while busy is ignored. It is not queued.
- `reset` in any state: go to IDLE. All buffers, `i` and `gen_count` clear to 0. No write occurs in the reset cycle.
- The register file's pattern-load lines must only be asserted while the engine is in IDLE or held in reset. The step controller guarantees this, and the engine does not check it.

## Timing
- Reset values: `ra`=0, `wd`=0, `regwrite`=0, `busy`=0, `done`=0, `gen_count`=0.
- `start` high at edge k puts LOAD_TOP in cycle k+1.
- Then: one LOAD_TOP cycle, one LOAD_CUR cycle, N FETCH/WRITE pairs, then DONE.
- `busy` is high for 2N+3 cycles, DONE included. `done` rises 2N+3 cycles after `start` was sampled. For N=8 that is 19 cycles.
- Row i is written during the WRITE cycle of pair i. The write takes effect at the end of that cycle, and the file shows it on `rd` in the following cycle.
- A `start` held high through DONE begins the next generation immediately after the IDLE cycle, giving 2N+4 cycles per generation back-to-back.

## Configuration
- `GOL_TORUS_EN` defined: the board is toroidal.
  - Row N-1 is the neighbour above row 0, and row 0 (taken from `row0`) is the neighbour below row N-1.
  - Column WIDTH-1 neighbours column 0.
- `GOL_TORUS_EN` undefined: cells off the board are dead.
  - LOAD_TOP still takes one cycle, but `prev` loads 0.
  - At i==N-1, FETCH loads `nxt` with 0.
  - Column -1 and column WIDTH read as 0.
- Latency is identical in both builds.

## Structure
- `gol_pkg`: the state enum `gol_state_t`, plus constants for the B3/S23 counts (`GOL_BIRTH`=3, `GOL_SURVIVE`=2).
- Sub-module `gol_row_rule`: combinational, WIDTH-parameterised. It maps (`prev`, `cur`, `nxt`) to the next row, with the column edge mode selected by the macro. It is instantiated once.

## Test plan
- Blinker: rows 2..4 = 8'b00010000, then `start`. After `done`, rows 3 = 8'b00111000 and all other rows are 0. A second step restores the original. `gen_count`=2.
- Block at rows 0..1 = 8'b00011000: one step leaves the board unchanged. Check that `regwrite` pulses exactly 8 times, with `ra` = 0..7 in order.
- Torus build, glider at rows 6..7 and row 0 near column 7: after 4 steps, every live cell is shifted by (+1 row, +1 column) with wrap. Non-torus build, same input: the glider cells at the board edge die.
- `start` held for 1 cycle: `busy` is high for 19 cycles and `done` is high exactly in cycle 19. Extra `start` pulses during `busy` do not change `gen_count`.
- `reset` asserted during the WRITE of row 3: the next cycle shows IDLE, `regwrite`=0 and `gen_count`=0. Rows 0..2 keep their new values and rows 3..7 keep their old values.
